// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and constants for the program-counter generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'b00,
        MTVEC_VECTORED = 2'b01
    } mtvec_mode_e;

    localparam int unsigned PC_STEP_32 = 4;
    localparam int unsigned PC_STEP_16 = 2;

    typedef enum logic [2:0] {
        SRC_TRAP = 3'd0,
        SRC_RET  = 3'd1,
        SRC_JUMP = 3'd2,
        SRC_HOLD = 3'd3,
        SRC_INCR = 3'd4
    } pc_src_e;

endpackage
`default_nettype wire

// File: rtl/pc_hist.sv
`default_nettype none
// ============================================================================
// Module      : pc_hist
// Description : Delayed-PC shift register with per-stage valid, stall, flush.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_hist #(
    parameter int unsigned          XLEN       = 32,
    parameter int unsigned          HIST_DEPTH = 2,
    parameter logic [XLEN-1:0]      RESET_VAL  = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic [XLEN-1:0]              pc_i,
    output logic [HIST_DEPTH*XLEN-1:0]   pc_hist_o,
    output logic [HIST_DEPTH-1:0]        pc_hist_vld_o
);

    logic [XLEN-1:0] r_hist [HIST_DEPTH];
    logic            r_vld  [HIST_DEPTH];

    generate
        for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_stage
            logic [XLEN-1:0] w_src;
            logic            w_vld_src;

            // Stage 0 is fed by the live PC and always marks a fresh entry valid.
            if (k == 0) begin : g_head
                assign w_src     = pc_i;
                assign w_vld_src = 1'b1;
            end else begin : g_tail
                assign w_src     = r_hist[k-1];
                assign w_vld_src = r_vld[k-1];
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_hist[k] <= RESET_VAL;
                end else if (!stall_i) begin
                    r_hist[k] <= w_src;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_vld[k] <= 1'b0;
                end else if (flush_i) begin
                    r_vld[k] <= 1'b0;
                end else if (!stall_i) begin
                    r_vld[k] <= w_vld_src;
                end
            end

            assign pc_hist_o[k*XLEN +: XLEN] = r_hist[k];
            assign pc_hist_vld_o[k]          = r_vld[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Fetch PC generator with trap/return/jump redirects and history.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN       = 32,
    parameter int unsigned      HIST_DEPTH = 2,
    parameter logic [XLEN-1:0]  RESET_VAL  = '0,
    parameter bit               C_EXT      = 1'b0,
    parameter int unsigned      CAUSE_W    = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        stall_i,
    input  logic                        incr_pc_i,
    input  logic                        compressed_i,
    input  logic                        exception_i,
    input  logic                        interrupt_i,
    input  logic [CAUSE_W-1:0]          cause_i,
    input  logic                        ret_i,
    input  logic                        load_arith_i,
    input  logic [XLEN-1:0]             arith_out_i,
    input  logic [XLEN-1:0]             mtvec_i,
    input  logic [XLEN-1:0]             mepc_i,
    input  logic                        flush_i,
    output logic [XLEN-1:0]             pc_o,
    output logic [HIST_DEPTH*XLEN-1:0]  pc_hist_o,
    output logic [HIST_DEPTH-1:0]       pc_hist_vld_o,
    output logic                        misalign_o
);

    localparam logic [XLEN-1:0] c_ret_mask = C_EXT ? ~XLEN'(1) : ~XLEN'(3);

    logic [XLEN-1:0] r_pc;
    logic            r_misalign;

    logic [XLEN-1:0] w_trap_base;
    logic [XLEN-1:0] w_cause_off;
    logic [XLEN-1:0] w_trap_target;
    logic [XLEN-1:0] w_ret_target;
    logic [XLEN-1:0] w_jump_target;
    logic            w_jump_bad;
    logic [XLEN-1:0] w_step;
    logic            w_reject;
    pc_src_e         w_src;
    logic [XLEN-1:0] w_next_pc;

    assign w_trap_base   = {mtvec_i[XLEN-1:2], 2'b00};
    assign w_cause_off   = XLEN'(cause_i) << 2;
    assign w_trap_target = (mtvec_i[1:0] == MTVEC_VECTORED && interrupt_i)
                         ? w_trap_base + w_cause_off : w_trap_base;
    assign w_ret_target  = mepc_i & c_ret_mask;
    assign w_jump_target = {arith_out_i[XLEN-1:1], 1'b0};
    assign w_jump_bad    = !C_EXT && arith_out_i[1];
    assign w_step        = (C_EXT && compressed_i) ? XLEN'(PC_STEP_16) : XLEN'(PC_STEP_32);

    always_comb begin
        w_src = SRC_HOLD;
        if (exception_i) begin
            w_src = SRC_TRAP;
        end else if (ret_i) begin
            w_src = SRC_RET;
        end else if (load_arith_i) begin
            w_src = SRC_JUMP;
        end else if (stall_i) begin
            w_src = SRC_HOLD;
        end else if (incr_pc_i) begin
            w_src = SRC_INCR;
        end
    end

    // A misaligned jump still wins priority, so lower-priority sources cannot sneak through.
    assign w_reject = (w_src == SRC_JUMP) && w_jump_bad;

    always_comb begin
        w_next_pc = r_pc;
        case (w_src)
            SRC_TRAP: w_next_pc = w_trap_target;
            SRC_RET:  w_next_pc = w_ret_target;
            SRC_JUMP: w_next_pc = w_reject ? r_pc : w_jump_target;
            SRC_INCR: w_next_pc = r_pc + w_step;
            default:  w_next_pc = r_pc;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc       <= RESET_VAL;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_next_pc;
            r_misalign <= w_reject;
        end
    end

    pc_hist #(
        .XLEN       (XLEN),
        .HIST_DEPTH (HIST_DEPTH),
        .RESET_VAL  (RESET_VAL)
    ) u_pc_hist (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .pc_i          (r_pc),
        .pc_hist_o     (pc_hist_o),
        .pc_hist_vld_o (pc_hist_vld_o)
    );

    assign pc_o       = r_pc;
    assign misalign_o = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen
// Description : Self-checking bench for pc_gen, C_EXT=0 and C_EXT=1 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        stall, incr, comp, exc, intr, ret, ld, flush;
    logic [4:0]  cause;
    logic [31:0] arith, mtvec, mepc;

    logic [31:0] pc_d    [2];
    logic [63:0] hist_d  [2];
    logic [1:0]  vld_d   [2];
    logic        mis_d   [2];

    int n_checks = 0;
    int n_fail   = 0;

    generate
        for (genvar c = 0; c < 2; c++) begin : g_dut
            pc_gen #(
                .XLEN       (32),
                .HIST_DEPTH (2),
                .RESET_VAL  (RV),
                .C_EXT      (c == 1),
                .CAUSE_W    (5)
            ) dut (
                .clk_i         (clk),
                .rst_i         (rst),
                .stall_i       (stall),
                .incr_pc_i     (incr),
                .compressed_i  (comp),
                .exception_i   (exc),
                .interrupt_i   (intr),
                .cause_i       (cause),
                .ret_i         (ret),
                .load_arith_i  (ld),
                .arith_out_i   (arith),
                .mtvec_i       (mtvec),
                .mepc_i        (mepc),
                .flush_i       (flush),
                .pc_o          (pc_d[c]),
                .pc_hist_o     (hist_d[c]),
                .pc_hist_vld_o (vld_d[c]),
                .misalign_o    (mis_d[c])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural PC, history list and pending misalign flag per config.
    logic [31:0] m_pc   [2];
    logic [31:0] m_hist [2][2];
    logic [1:0]  m_vld  [2];
    logic        m_mis  [2];

    function automatic logic model_reject(int c);
        return !exc && !ret && ld && (c == 0) && arith[1];
    endfunction

    function automatic logic [31:0] model_next(int c, logic [31:0] pc);
        if (exc) begin
            if (mtvec[1:0] == 2'b01 && intr) return (mtvec & ~32'd3) + {25'd0, cause, 2'b00};
            return mtvec & ~32'd3;
        end
        if (ret) return (c == 1) ? (mepc & ~32'd1) : (mepc & ~32'd3);
        if (ld) return model_reject(c) ? pc : (arith & ~32'd1);
        if (stall) return pc;
        if (incr) return pc + ((c == 1 && comp) ? 32'd2 : 32'd4);
        return pc;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_pc[c]      <= RV;
                m_hist[c][0] <= RV;
                m_hist[c][1] <= RV;
                m_vld[c]     <= 2'b00;
                m_mis[c]     <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                m_pc[c]  <= model_next(c, m_pc[c]);
                m_mis[c] <= model_reject(c);
                if (!stall) begin
                    m_hist[c][0] <= m_pc[c];
                    m_hist[c][1] <= m_hist[c][0];
                end
                if (flush)       m_vld[c] <= 2'b00;
                else if (!stall) m_vld[c] <= {m_vld[c][0], 1'b1};
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            check($sformatf("pc[%0d]", c), pc_d[c], m_pc[c]);
            check($sformatf("hist0[%0d]", c), hist_d[c][31:0], m_hist[c][0]);
            check($sformatf("hist1[%0d]", c), hist_d[c][63:32], m_hist[c][1]);
            check($sformatf("vld[%0d]", c), {30'd0, vld_d[c]}, {30'd0, m_vld[c]});
            check($sformatf("mis[%0d]", c), {31'd0, mis_d[c]}, {31'd0, m_mis[c]});
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        {stall, incr, comp, exc, intr, ret, ld, flush} = '0;
        cause = '0; arith = '0; mtvec = '0; mepc = '0;
        tick();
        check("rst_pc", pc_d[0], 32'h100);
        check("rst_hist", hist_d[1][63:32], 32'h100);
        check("rst_vld", {30'd0, vld_d[0]}, 32'd0);
        check("rst_mis", {31'd0, mis_d[0]}, 32'd0);

        rst = 1'b0; incr = 1'b1;
        tick(); tick(); tick();
        check("incr_pc", pc_d[0], 32'h10C);
        check("incr_h0", hist_d[0][31:0], 32'h108);
        check("incr_h1", hist_d[0][63:32], 32'h104);
        check("incr_vld", {30'd0, vld_d[0]}, 32'd3);

        incr = 1'b0; exc = 1'b1; intr = 1'b1; cause = 5'd7; mtvec = 32'h8000_0001;
        tick();
        check("trap_vec", pc_d[0], 32'h8000_001C);
        intr = 1'b0;
        tick();
        check("trap_exc", pc_d[1], 32'h8000_0000);

        exc = 1'b0; ld = 1'b1; arith = 32'h200;
        tick();
        check("jump_200", pc_d[0], 32'h200);
        arith = 32'h302;
        tick();
        ld = 1'b0;
        check("misal_pc", pc_d[0], 32'h200);
        check("misal_pulse", {31'd0, mis_d[0]}, 32'd1);
        check("c_jump_302", pc_d[1], 32'h302);
        tick();
        check("misal_end", {31'd0, mis_d[0]}, 32'd0);
        ld = 1'b1; arith = 32'h301;
        tick();
        ld = 1'b0;
        check("jump_301", pc_d[0], 32'h300);
        tick();
        check("jump_301_nomis", {31'd0, mis_d[0]}, 32'd0);

        ld = 1'b1; arith = 32'h400;
        tick();
        ld = 1'b0; incr = 1'b1; comp = 1'b1;
        tick();
        check("c_step2", pc_d[1], 32'h402);
        check("nc_step4", pc_d[0], 32'h404);
        comp = 1'b0;
        tick();
        check("c_step4", pc_d[1], 32'h406);
        incr = 1'b0; ld = 1'b1; arith = 32'hFFFF_FFFC;
        tick();
        ld = 1'b0; incr = 1'b1;
        tick();
        check("wrap", pc_d[1], 32'h0);

        incr = 1'b0; stall = 1'b1; ret = 1'b1; mepc = 32'h500;
        tick();
        check("ret_stall_pc", pc_d[1], 32'h500);
        check("ret_stall_h0", hist_d[1][31:0], 32'hFFFF_FFFC);
        check("ret_stall_h1", hist_d[1][63:32], 32'h406);
        ret = 1'b0; stall = 1'b0; flush = 1'b1;
        tick();
        check("flush_h0", hist_d[1][31:0], 32'h500);
        check("flush_vld", {30'd0, vld_d[1]}, 32'd0);
        flush = 1'b0;
        tick();
        check("post_flush_vld", {30'd0, vld_d[1]}, 32'd1);
        stall = 1'b1; flush = 1'b1;
        tick();
        check("stall_flush_vld", {30'd0, vld_d[0]}, 32'd0);
        stall = 1'b0; flush = 1'b0; ret = 1'b1; mepc = 32'h507;
        tick();
        ret = 1'b0;
        check("ret_align0", pc_d[0], 32'h504);
        check("ret_align1", pc_d[1], 32'h506);

        ld = 1'b1; arith = 32'h302;
        @(posedge clk);
        #1;
        rst = 1'b1; ld = 1'b0;
        #1;
        check("async_rst_mis", {31'd0, mis_d[0]}, 32'd0);
        check("async_rst_pc", pc_d[1], 32'h100);
        tick();
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
